// File: rtl/instruction_cache.sv
// Instruction window cache: fetches ISA_DEPTH-word blocks from DDR one word at a time
// and serves the instruction at i_addr_ins with one cycle of read latency.
module instruction_cache #(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int ISA_WIDTH       = 32,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int DDR_INS_BASE    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH_MEM-1:0] i_addr_ins,
  output logic [ISA_WIDTH-1:0]      o_ins_out,
  output logic                      o_ins_cache_rdy,
  output logic [3:0]                o_st_cur_ins_cache,
  output logic [9:0]                o_load_times,
  output logic                      o_ddr_rd_req,
  output logic [DDR_ADDR_WIDTH-1:0] o_ddr_rd_addr,
  input  logic [ISA_WIDTH-1:0]      i_ddr_rd_data,
  input  logic                      i_ddr_rd_data_valid
);
  localparam int IDX_W = $clog2(ISA_DEPTH);
  localparam int BLK_W = ADDR_WIDTH_MEM - IDX_W;

  typedef enum logic [3:0] {
    START    = 4'd1,
    LOAD_INS = 4'd2,
    SENT_INS = 4'd3
  } state_t;

  state_t                    r_state;
  state_t                    w_nextState;
  logic [ISA_WIDTH-1:0]      r_mem [ISA_DEPTH];
  logic [BLK_W-1:0]          r_blk;
  logic [IDX_W-1:0]          r_wordCnt;
  logic [ISA_WIDTH-1:0]      r_insOut;
  logic [9:0]                r_loadTimes;
  logic                      r_ddrRdReq;
  logic [DDR_ADDR_WIDTH-1:0] r_ddrRdAddr;
  logic                      r_hitQ;
  logic [ADDR_WIDTH_MEM-1:0] r_addrQ;

  logic [BLK_W-1:0]          w_addrBlk;
  logic                      w_placeholder;
  logic                      w_endOfProg;
  logic                      w_hit;
  logic [ADDR_WIDTH_MEM-1:0] w_wordAddr;
  logic [DDR_ADDR_WIDTH-1:0] w_ddrAddr;
  logic                      w_wordAccept;
  logic                      w_loadDone;

  // The window is block-aligned, so a hit is simply a matching block number.
  assign w_addrBlk     = i_addr_ins[ADDR_WIDTH_MEM-1:IDX_W];
  assign w_placeholder = i_addr_ins[ADDR_WIDTH_MEM-1];
  assign w_endOfProg   = i_addr_ins >= ADDR_WIDTH_MEM'(TOTAL_ISA_DEPTH);
  assign w_hit         = (r_loadTimes != 10'd0) && (w_addrBlk == r_blk);
  assign w_wordAddr    = {r_blk, r_wordCnt};
  assign w_ddrAddr     = DDR_ADDR_WIDTH'(DDR_INS_BASE) + (DDR_ADDR_WIDTH'(w_wordAddr) << 3);
  assign w_wordAccept  = (r_state == LOAD_INS) && r_ddrRdReq && i_ddr_rd_data_valid;
  assign w_loadDone    = w_wordAccept && (r_wordCnt == IDX_W'(ISA_DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= START;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      START:    w_nextState = LOAD_INS;
      LOAD_INS: if (w_loadDone) w_nextState = SENT_INS;
      SENT_INS: if (!w_placeholder && !w_endOfProg && !w_hit) w_nextState = LOAD_INS;
      default:  w_nextState = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wordAccept) r_mem[r_wordCnt] <= i_ddr_rd_data;
  end

  // Request is raised in the cycle after the previous word lands, giving the one-cycle gap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blk       <= '0;
      r_wordCnt   <= '0;
      r_insOut    <= '0;
      r_loadTimes <= '0;
      r_ddrRdReq  <= 1'b0;
      r_ddrRdAddr <= '0;
      r_hitQ      <= 1'b0;
      r_addrQ     <= '0;
    end else begin
      case (r_state)
        START: begin
          r_blk     <= '0;
          r_wordCnt <= '0;
          r_hitQ    <= 1'b0;
        end
        LOAD_INS: begin
          r_hitQ <= 1'b0;
          if (r_ddrRdReq) begin
            if (i_ddr_rd_data_valid) begin
              r_ddrRdReq <= 1'b0;
              r_wordCnt  <= r_wordCnt + 1'b1;
              if (w_loadDone) r_loadTimes <= 10'(r_blk) + 10'd1;
            end
          end else begin
            r_ddrRdReq  <= 1'b1;
            r_ddrRdAddr <= w_ddrAddr;
          end
        end
        SENT_INS: begin
          if (w_placeholder || w_endOfProg) begin
            r_hitQ <= 1'b0;
          end else if (w_hit) begin
            r_insOut <= r_mem[i_addr_ins[IDX_W-1:0]];
            r_addrQ  <= i_addr_ins;
            r_hitQ   <= 1'b1;
          end else begin
            r_blk     <= w_addrBlk;
            r_wordCnt <= '0;
            r_hitQ    <= 1'b0;
          end
        end
        default: r_hitQ <= 1'b0;
      endcase
    end
  end

  assign o_ins_out          = r_insOut;
  assign o_ins_cache_rdy    = (r_state == SENT_INS) && r_hitQ && (r_addrQ == i_addr_ins);
  assign o_st_cur_ins_cache = r_state;
  assign o_load_times       = r_loadTimes;
  assign o_ddr_rd_req       = r_ddrRdReq;
  assign o_ddr_rd_addr      = r_ddrRdAddr;
endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: a DDR responder with random latency feeds word i as
// 0x1000_0000+i; a block-level model predicts loads, load_times and served words.
module tb_instruction_cache;
  localparam int          ISA_DEPTH = 64;
  localparam int          TOTAL     = 128;
  localparam logic [31:0] DATA_BASE = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic [15:0] addrIns;
  logic [31:0] insOut;
  logic        insRdy;
  logic [3:0]  stCur;
  logic [9:0]  loadTimes;
  logic        ddrReq;
  logic [27:0] ddrAddr;
  logic [31:0] ddrData;
  logic        ddrValid;

  int          nCompared   = 0;
  int          nMismatched = 0;
  int          validsSent  = 0;
  int          reqGlitches = 0;
  int          modelBlock  = -1;
  logic [27:0] reqLog[$];

  instruction_cache dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_addr_ins          (addrIns),
    .o_ins_out           (insOut),
    .o_ins_cache_rdy     (insRdy),
    .o_st_cur_ins_cache  (stCur),
    .o_load_times        (loadTimes),
    .o_ddr_rd_req        (ddrReq),
    .o_ddr_rd_addr       (ddrAddr),
    .i_ddr_rd_data       (ddrData),
    .i_ddr_rd_data_valid (ddrValid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // DDR model: one word per request, 1..3 cycles latency, word index taken from the byte address.
  initial begin : ddrResponder
    bit          pending;
    int          countdown;
    logic [27:0] heldAddr;
    pending  = 1'b0;
    countdown = 0;
    heldAddr = '0;
    ddrValid = 1'b0;
    ddrData  = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        pending  = 1'b0;
        ddrValid = 1'b0;
      end else if (ddrValid) begin
        ddrValid = 1'b0;
        if (ddrReq) reqGlitches++;
      end else if (pending) begin
        if (!ddrReq || ddrAddr !== heldAddr) reqGlitches++;
        countdown--;
        if (countdown == 0) begin
          ddrValid = 1'b1;
          ddrData  = DATA_BASE + 32'(heldAddr >> 3);
          pending  = 1'b0;
          validsSent++;
        end
      end else if (ddrReq) begin
        pending   = 1'b1;
        heldAddr  = ddrAddr;
        countdown = $urandom_range(1, 3);
        reqLog.push_back(ddrAddr);
      end
    end
  end

  task automatic wait_state(input logic [3:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (stCur === st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rdy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (insRdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    addrIns = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nCompared++; if (insOut !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_ins_out: got %h want 0", insOut); end
    nCompared++; if (insRdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_rdy: got %b want 0", insRdy); end
    nCompared++; if (stCur !== 4'd1) begin nMismatched++; $display("[TB] FAIL reset_state: got %0d want 1", stCur); end
    nCompared++; if (loadTimes !== 10'd0) begin nMismatched++; $display("[TB] FAIL reset_load_times: got %0d want 0", loadTimes); end
    nCompared++; if (ddrReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req: got %b want 0", ddrReq); end
    nCompared++; if (ddrAddr !== 28'd0) begin nMismatched++; $display("[TB] FAIL reset_ddr_addr: got %h want 0", ddrAddr); end
    reqLog.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    modelBlock = -1;
  endtask

  task automatic test_initial_load();
    bit ok;
    wait_state(4'd3, 1500, ok);
    nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL initial_load_done: got timeout want state 3"); end
    nCompared++; if (reqLog.size() != ISA_DEPTH) begin nMismatched++; $display("[TB] FAIL initial_req_count: got %0d want %0d", reqLog.size(), ISA_DEPTH); end
    for (int i = 0; i < reqLog.size() && i < ISA_DEPTH; i++) begin
      nCompared++; if (reqLog[i] !== 28'(i * 8)) begin nMismatched++; $display("[TB] FAIL initial_req_addr[%0d]: got %h want %h", i, reqLog[i], 28'(i * 8)); end
    end
    nCompared++; if (loadTimes !== 10'd1) begin nMismatched++; $display("[TB] FAIL initial_load_times: got %0d want 1", loadTimes); end
    nCompared++; if (insRdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL initial_rdy_first_cycle: got %b want 0", insRdy); end
    @(negedge clk);
    nCompared++; if (insRdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL initial_rdy: got %b want 1", insRdy); end
    nCompared++; if (insOut !== DATA_BASE) begin nMismatched++; $display("[TB] FAIL initial_ins_out: got %h want %h", insOut, DATA_BASE); end
    modelBlock = 0;
  endtask

  task automatic test_address_change();
    int cur;
    int nxt;
    int logSize;
    cur = 5;
    @(posedge clk); #1;
    addrIns = 16'(cur);
    repeat (2) @(negedge clk);
    logSize = reqLog.size();
    for (int k = 0; k < 8; k++) begin
      nxt = (k == 0) ? 6 : int'($urandom_range(0, ISA_DEPTH - 1));
      if (nxt == cur) nxt = (nxt + 1) % ISA_DEPTH;
      @(posedge clk); #1;
      addrIns = 16'(nxt);
      @(negedge clk);
      nCompared++; if (insRdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL change_rdy_drop %0d->%0d: got %b want 0", cur, nxt, insRdy); end
      @(negedge clk);
      nCompared++; if (insRdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL change_rdy_rise %0d: got %b want 1", nxt, insRdy); end
      nCompared++; if (insOut !== DATA_BASE + 32'(nxt)) begin nMismatched++; $display("[TB] FAIL change_ins_out %0d: got %h want %h", nxt, insOut, DATA_BASE + 32'(nxt)); end
      cur = nxt;
    end
    nCompared++; if (reqLog.size() != logSize) begin nMismatched++; $display("[TB] FAIL change_no_ddr: got %0d reqs want %0d", reqLog.size(), logSize); end
  endtask

  task automatic test_boundary_crossing();
    bit ok;
    int target;
    target = ISA_DEPTH * int'(loadTimes);
    reqLog.delete();
    @(posedge clk); #1;
    addrIns = 16'(target);
    wait_state(4'd2, 5, ok);
    nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL boundary_enter_load: got state %0d want 2", stCur); end
    nCompared++; if (loadTimes !== 10'd1) begin nMismatched++; $display("[TB] FAIL boundary_load_times_during: got %0d want 1", loadTimes); end
    wait_state(4'd3, 1500, ok);
    nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL boundary_load_done: got timeout want state 3"); end
    nCompared++; if (reqLog.size() != ISA_DEPTH) begin nMismatched++; $display("[TB] FAIL boundary_req_count: got %0d want %0d", reqLog.size(), ISA_DEPTH); end
    for (int i = 0; i < reqLog.size() && i < ISA_DEPTH; i++) begin
      nCompared++; if (reqLog[i] !== 28'((target + i) * 8)) begin nMismatched++; $display("[TB] FAIL boundary_req_addr[%0d]: got %h want %h", i, reqLog[i], 28'((target + i) * 8)); end
    end
    nCompared++; if (loadTimes !== 10'd2) begin nMismatched++; $display("[TB] FAIL boundary_load_times: got %0d want 2", loadTimes); end
    @(negedge clk);
    nCompared++; if (insRdy !== 1'b1) begin nMismatched++; $display("[TB] FAIL boundary_rdy: got %b want 1", insRdy); end
    nCompared++; if (insOut !== DATA_BASE + 32'(target)) begin nMismatched++; $display("[TB] FAIL boundary_ins_out: got %h want %h", insOut, DATA_BASE + 32'(target)); end
    modelBlock = 1;
  endtask

  task automatic test_placeholder();
    bit ok;
    reqLog.delete();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      addrIns = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
      @(negedge clk);
      nCompared++; if (stCur !== 4'd3) begin nMismatched++; $display("[TB] FAIL placeholder_state %h: got %0d want 3", addrIns, stCur); end
      nCompared++; if (insRdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL placeholder_rdy %h: got %b want 0", addrIns, insRdy); end
      nCompared++; if (ddrReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL placeholder_req %h: got %b want 0", addrIns, ddrReq); end
    end
    nCompared++; if (reqLog.size() != 0) begin nMismatched++; $display("[TB] FAIL placeholder_no_ddr: got %0d reqs want 0", reqLog.size()); end
    @(posedge clk); #1;
    addrIns = 16'd3;
    wait_state(4'd3, 5, ok);
    wait_rdy(1500, ok);
    nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL jump_back_ready: got timeout want rdy"); end
    nCompared++; if (loadTimes !== 10'd1) begin nMismatched++; $display("[TB] FAIL jump_back_load_times: got %0d want 1", loadTimes); end
    nCompared++; if (reqLog.size() != ISA_DEPTH) begin nMismatched++; $display("[TB] FAIL jump_back_req_count: got %0d want %0d", reqLog.size(), ISA_DEPTH); end
    nCompared++; if (reqLog.size() > 0 && reqLog[0] !== 28'd0) begin nMismatched++; $display("[TB] FAIL jump_back_first_addr: got %h want 0", reqLog[0]); end
    nCompared++; if (insOut !== DATA_BASE + 32'd3) begin nMismatched++; $display("[TB] FAIL jump_back_ins_out: got %h want %h", insOut, DATA_BASE + 32'd3); end
    modelBlock = 0;
  endtask

  task automatic test_end_of_program();
    reqLog.delete();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      addrIns = (c == 0) ? 16'(TOTAL) : 16'($urandom_range(TOTAL, 16'h7FFF));
      @(negedge clk);
      nCompared++; if (stCur !== 4'd3) begin nMismatched++; $display("[TB] FAIL end_state %h: got %0d want 3", addrIns, stCur); end
      nCompared++; if (insRdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL end_rdy %h: got %b want 0", addrIns, insRdy); end
      nCompared++; if (ddrReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL end_req %h: got %b want 0", addrIns, ddrReq); end
    end
    nCompared++; if (reqLog.size() != 0) begin nMismatched++; $display("[TB] FAIL end_no_ddr: got %0d reqs want 0", reqLog.size()); end
  endtask

  // Random jumps across the program; a load is expected exactly when the target block is not resident.
  task automatic test_random_walk();
    bit ok;
    int a;
    int blk;
    int wantReqs;
    for (int s = 0; s < 24; s++) begin
      a = $urandom_range(0, TOTAL - 1);
      blk = a / ISA_DEPTH;
      wantReqs = (blk != modelBlock) ? ISA_DEPTH : 0;
      reqLog.delete();
      @(posedge clk); #1;
      addrIns = 16'(a);
      wait_rdy(1500, ok);
      nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL walk_ready %0d: got timeout want rdy", a); end
      nCompared++; if (insOut !== DATA_BASE + 32'(a)) begin nMismatched++; $display("[TB] FAIL walk_ins_out %0d: got %h want %h", a, insOut, DATA_BASE + 32'(a)); end
      nCompared++; if (loadTimes !== 10'(blk + 1)) begin nMismatched++; $display("[TB] FAIL walk_load_times %0d: got %0d want %0d", a, loadTimes, blk + 1); end
      nCompared++; if (reqLog.size() != wantReqs) begin nMismatched++; $display("[TB] FAIL walk_req_count %0d: got %0d want %0d", a, reqLog.size(), wantReqs); end
      if (wantReqs != 0 && reqLog.size() > 0) begin
        nCompared++; if (reqLog[0] !== 28'(blk * ISA_DEPTH * 8)) begin nMismatched++; $display("[TB] FAIL walk_first_addr %0d: got %h want %h", a, reqLog[0], 28'(blk * ISA_DEPTH * 8)); end
      end
      modelBlock = blk;
    end
    nCompared++; if (reqGlitches != 0) begin nMismatched++; $display("[TB] FAIL req_protocol: got %0d violations want 0", reqGlitches); end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    int v0;
    int target;
    target = (modelBlock == 0) ? ISA_DEPTH + int'($urandom_range(0, ISA_DEPTH - 1)) : int'($urandom_range(0, ISA_DEPTH - 1));
    v0 = validsSent;
    @(posedge clk); #1;
    addrIns = 16'(target);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      if (validsSent >= v0 + 10) begin
        ok = 1'b1;
        break;
      end
    end
    nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL midload_progress: got %0d words want 10", validsSent - v0); end
    #1;
    rst = 1'b0;
    addrIns = 16'd7;
    @(negedge clk);
    nCompared++; if (insOut !== 32'd0) begin nMismatched++; $display("[TB] FAIL midload_ins_out: got %h want 0", insOut); end
    nCompared++; if (insRdy !== 1'b0) begin nMismatched++; $display("[TB] FAIL midload_rdy: got %b want 0", insRdy); end
    nCompared++; if (stCur !== 4'd1) begin nMismatched++; $display("[TB] FAIL midload_state: got %0d want 1", stCur); end
    nCompared++; if (loadTimes !== 10'd0) begin nMismatched++; $display("[TB] FAIL midload_load_times: got %0d want 0", loadTimes); end
    nCompared++; if (ddrReq !== 1'b0) begin nMismatched++; $display("[TB] FAIL midload_req: got %b want 0", ddrReq); end
    nCompared++; if (ddrAddr !== 28'd0) begin nMismatched++; $display("[TB] FAIL midload_ddr_addr: got %h want 0", ddrAddr); end
    repeat (3) @(posedge clk);
    reqLog.delete();
    #1;
    rst = 1'b1;
    wait_state(4'd3, 1500, ok);
    nCompared++; if (!ok) begin nMismatched++; $display("[TB] FAIL midload_reload_done: got timeout want state 3"); end
    nCompared++; if (reqLog.size() > 0 && reqLog[0] !== 28'd0) begin nMismatched++; $display("[TB] FAIL midload_first_addr: got %h want 0", reqLog[0]); end
    nCompared++; if (reqLog.size() != ISA_DEPTH) begin nMismatched++; $display("[TB] FAIL midload_req_count: got %0d want %0d", reqLog.size(), ISA_DEPTH); end
    nCompared++; if (loadTimes !== 10'd1) begin nMismatched++; $display("[TB] FAIL midload_load_times_after: got %0d want 1", loadTimes); end
    wait_rdy(10, ok);
    nCompared++; if (!ok || insOut !== DATA_BASE + 32'd7) begin nMismatched++; $display("[TB] FAIL midload_ins_out_after: got %h rdy %b want %h", insOut, insRdy, DATA_BASE + 32'd7); end
    modelBlock = 0;
  endtask

  initial begin
    rst = 1'b0;
    addrIns = 16'd0;
    test_reset();
    test_initial_load();
    test_address_change();
    test_boundary_crossing();
    test_placeholder();
    test_end_of_program();
    test_random_walk();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
